// File: rtl/pipe_ctrl.sv
// Per-cycle arbitration of MIPS pipeline latch enables/flushes from cache, hazard, branch and halt inputs.
// Controls are combinational (same cycle); state and saturating perf counters update on the rising edge.
module pipe_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_mem,
  input  logic        dWEN_mem,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        branch_taken_ex,
  input  logic        halt_mem,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halt,
  output logic        dwait,
  output logic [15:0] stall_cnt,
  output logic [15:0] squash_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] squash_q, squash_d;
  logic        mem_op, mem_busy, load_use;
  logic        stall_inc, squash_inc;

  assign mem_op   = dREN_mem | dWEN_mem;
  assign mem_busy = mem_op & ~dhit;
  assign load_use = idex_memread & (idex_rd != 5'd0) &
                    ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halt        = 1'b0;
    dwait       = 1'b0;
    squash_inc  = 1'b0;
    if (RST) begin
      state_d = RUN;
    end else begin
      case (state_q)
        HALT: begin
          halt = 1'b1;
        end
        default: begin
          dwait = (state_q == DWAIT);
          if (mem_busy) begin
            state_d = DWAIT;
          end else if (!ihit) begin
            // Data access just finished but fetch is stalled: retire the MEM
            // result and leave a bubble behind it so it is not replayed.
            if (mem_op) begin
              memwb_en    = 1'b1;
              exmem_flush = 1'b1;
            end
            state_d = RUN;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (branch_taken_ex) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              squash_inc = 1'b1;
            end else if (load_use) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end
            state_d = halt_mem ? HALT : RUN;
          end
        end
      endcase
    end
  end

  assign stall_inc = ~RST & (state_q != HALT) & ~pc_en;

  always_comb begin
    stall_d  = stall_q;
    squash_d = squash_q;
    if (stall_inc && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
    if (squash_inc && (squash_q != 16'hFFFF))
      squash_d = squash_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      stall_q  <= 16'd0;
      squash_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      squash_q <= squash_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign squash_cnt = squash_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: the driver queues expected outputs, a negedge monitor pops and checks them.
module tb_pipe_ctrl;

  bit          CLK = 1'b0;
  logic        RST, ihit, dhit, dREN_mem, dWEN_mem, idex_memread;
  logic [4:0]  idex_rd, ifid_rs, ifid_rt;
  logic        ifid_uses_rt, branch_taken_ex, halt_mem;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        halt, dwait;
  logic [15:0] stall_cnt, squash_cnt;

  pipe_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .branch_taken_ex(branch_taken_ex), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .halt(halt), .dwait(dwait),
    .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
  );

  always #5 CLK = ~CLK;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl, halt, dwait}
  localparam logic [10:0] C_ZERO   = 11'b00000_0000_00;
  localparam logic [10:0] C_RUN    = 11'b11111_0000_00;
  localparam logic [10:0] C_LU     = 11'b00111_0100_00;
  localparam logic [10:0] C_BR     = 11'b11111_1100_00;
  localparam logic [10:0] C_DW     = 11'b00000_0000_01;
  localparam logic [10:0] C_DWDONE = 11'b00001_0010_01;
  localparam logic [10:0] C_HALT   = 11'b00000_0000_10;

  string       q_name[$];
  logic [10:0] q_ctl[$];
  bit          q_chk[$];
  logic [15:0] q_st[$];
  logic [15:0] q_sq[$];

  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge CLK) begin
    if (q_ctl.size() > 0) begin
      string       nm;
      logic [10:0] ectl, actl;
      bit          k;
      logic [15:0] est, esq;
      nm   = q_name.pop_front();
      ectl = q_ctl.pop_front();
      k    = q_chk.pop_front();
      est  = q_st.pop_front();
      esq  = q_sq.pop_front();
      actl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, dwait};
      n_checks++;
      if (actl !== ectl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b want %b", nm, actl, ectl);
      end
      if (k) begin
        n_checks += 2;
        if (stall_cnt !== est) begin
          n_fail++;
          $display("FAIL %s stall_cnt: got %0h want %0h", nm, stall_cnt, est);
        end
        if (squash_cnt !== esq) begin
          n_fail++;
          $display("FAIL %s squash_cnt: got %0h want %0h", nm, squash_cnt, esq);
        end
      end
    end
  end

  task automatic clr();
    RST = 1'b0; ihit = 1'b0; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
    idex_memread = 1'b0; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    ifid_uses_rt = 1'b0; branch_taken_ex = 1'b0; halt_mem = 1'b0;
  endtask

  task automatic exp_cyc(input string nm, input logic [10:0] c, input bit k,
                         input logic [15:0] st, input logic [15:0] sq);
    q_name.push_back(nm);
    q_ctl.push_back(c);
    q_chk.push_back(k);
    q_st.push_back(st);
    q_sq.push_back(sq);
    @(posedge CLK); #1;
  endtask

  initial begin
    clr();
    RST = 1'b1;
    @(posedge CLK); #1;

    // Reset gates all outputs even with ihit high
    clr(); RST = 1'b1; ihit = 1'b1;
    exp_cyc("rst0", C_ZERO, 1'b0, 16'd0, 16'd0);
    exp_cyc("rst1", C_ZERO, 1'b1, 16'd0, 16'd0);

    clr(); ihit = 1'b1;
    for (int i = 0; i < 10; i++) exp_cyc("run", C_RUN, 1'b1, 16'd0, 16'd0);

    // Load-use on rs, then the bubble cycle
    idex_memread = 1'b1; idex_rd = 5'd8; ifid_rs = 5'd8;
    exp_cyc("lu_rs", C_LU, 1'b1, 16'd0, 16'd0);
    idex_memread = 1'b0;
    exp_cyc("lu_after", C_RUN, 1'b1, 16'd1, 16'd0);
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0;
    exp_cyc("lu_r0", C_RUN, 1'b1, 16'd1, 16'd0);
    idex_rd = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_uses_rt = 1'b0;
    exp_cyc("lu_rt_unused", C_RUN, 1'b1, 16'd1, 16'd0);
    ifid_uses_rt = 1'b1;
    exp_cyc("lu_rt", C_LU, 1'b1, 16'd1, 16'd0);
    clr(); ihit = 1'b1;
    exp_cyc("lu_rt_after", C_RUN, 1'b1, 16'd2, 16'd0);

    // Data miss for 3 cycles, then dhit with ihit low
    dREN_mem = 1'b1; dhit = 1'b0;
    exp_cyc("miss1", C_ZERO, 1'b1, 16'd2, 16'd0);
    exp_cyc("miss2", C_DW, 1'b1, 16'd3, 16'd0);
    exp_cyc("miss3", C_DW, 1'b1, 16'd4, 16'd0);
    dhit = 1'b1; ihit = 1'b0;
    exp_cyc("miss_done", C_DWDONE, 1'b1, 16'd5, 16'd0);
    clr(); ihit = 1'b1;
    exp_cyc("miss_run", C_RUN, 1'b1, 16'd6, 16'd0);
    dWEN_mem = 1'b1; dhit = 1'b1;
    exp_cyc("dhit_ihit", C_RUN, 1'b1, 16'd6, 16'd0);
    clr();
    exp_cyc("imiss", C_ZERO, 1'b1, 16'd6, 16'd0);
    ihit = 1'b1;
    exp_cyc("imiss_after", C_RUN, 1'b1, 16'd7, 16'd0);

    // Branch beats load-use; branch without ihit does not squash
    branch_taken_ex = 1'b1; idex_memread = 1'b1; idex_rd = 5'd8; ifid_rs = 5'd8;
    exp_cyc("br_lu", C_BR, 1'b1, 16'd7, 16'd0);
    clr(); ihit = 1'b1;
    exp_cyc("br_after", C_RUN, 1'b1, 16'd7, 16'd1);
    clr(); branch_taken_ex = 1'b1;
    exp_cyc("br_noihit", C_ZERO, 1'b1, 16'd7, 16'd1);
    clr(); ihit = 1'b1;
    exp_cyc("br_noihit_after", C_RUN, 1'b1, 16'd8, 16'd1);

    // Halt is sticky and ignores inputs
    halt_mem = 1'b1;
    exp_cyc("halt_enter", C_RUN, 1'b1, 16'd8, 16'd1);
    for (int i = 0; i < 5; i++) begin
      clr();
      ihit = i[0]; dhit = ~i[0]; dREN_mem = 1'b1; branch_taken_ex = 1'b1;
      exp_cyc("halted", C_HALT, 1'b1, 16'd8, 16'd1);
    end
    clr(); RST = 1'b1; ihit = 1'b1;
    exp_cyc("halt_rst", C_ZERO, 1'b1, 16'd8, 16'd1);
    clr(); ihit = 1'b1;
    exp_cyc("halt_rst_run", C_RUN, 1'b1, 16'd0, 16'd0);

    // Long miss saturates stall_cnt
    clr(); dREN_mem = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(posedge CLK); #1;
    end
    exp_cyc("sat0", C_DW, 1'b1, 16'hFFFF, 16'd0);
    exp_cyc("sat1", C_DW, 1'b1, 16'hFFFF, 16'd0);
    RST = 1'b1;
    exp_cyc("dw_rst", C_ZERO, 1'b1, 16'hFFFF, 16'd0);
    clr(); ihit = 1'b1;
    exp_cyc("dw_rst_run0", C_RUN, 1'b1, 16'd0, 16'd0);
    exp_cyc("dw_rst_run1", C_RUN, 1'b1, 16'd0, 16'd0);

    repeat (2) @(posedge CLK);
    n_checks++;
    if (q_ctl.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q_ctl.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS datapath. It drives the enable, flush and PC-enable controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches. Its inputs are the cache hit signals, the load-use hazard fields, branch resolution from EX and halt from MEM. It sits beside the latches in the datapath top and replaces per-latch `ihit` gating with one arbitrated decision per cycle. It also tracks a sticky halt state and saturating stall/squash performance counters.

## Interface
- No parameters.
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- ihit  in  1  instruction fetch hit this cycle
- dhit  in  1  data access completes this cycle
- dREN_mem, dWEN_mem  in  1 each  MEM-stage instruction is a load / store
- idex_memread  in  1  instruction in ID/EX is a load
- idex_rd  in  5  destination register of ID/EX instruction
- ifid_rs, ifid_rt  in  5 each  source registers of IF/ID instruction
- ifid_uses_rt  in  1  IF/ID instruction reads rt
- branch_taken_ex  in  1  EX resolved taken branch/jump (redirect)
- halt_mem  in  1  halt instruction is in MEM
- pc_en  out  1  PC register update enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch capture enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch clears to zero; flush overrides en at the latch
- halt  out  1  sticky halted indicator
- dwait  out  1  state == DWAIT
- stall_cnt  out  16  saturating count of stalled cycles
- squash_cnt  out  16  saturating count of branch squashes

## Operation
- States: RUN, DWAIT, HALT. Reset state RUN.
- mem_busy = (dREN_mem | dWEN_mem) & ~dhit.
- load_use = idex_memread & (idex_rd != 0) & ((idex_rd == ifid_rs) | (ifid_uses_rt & idex_rd == ifid_rt)).
- Decisions in RUN/DWAIT, highest priority first. Every output not listed is 0.
  - A. mem_busy: all en = 0, pc_en = 0. Next state DWAIT.
  - B. ~mem_busy & ~ihit:
    - If dREN_mem|dWEN_mem (dhit completing): memwb_en = 1, exmem_flush = 1. Everything else is frozen.
    - Otherwise everything is frozen.
    - Next state RUN.
  - C. ~mem_busy & ihit: all en = 1, pc_en = 1. Then apply:
    - branch_taken_ex: ifid_flush = 1, idex_flush = 1. Takes priority over load_use.
    - else load_use: pc_en = 0, ifid_en = 0, idex_flush = 1. ID/EX receives a bubble; EX/MEM and MEM/WB advance.
    - halt_mem: next state HALT. The branch and load-use modifiers still apply.
    - Otherwise next state RUN.
- HALT: all en = 0, all flush = 0, pc_en = 0, halt = 1. HALT is left only via RST; all other inputs are ignored.
- stall_cnt increments when state != HALT, RST = 0 and pc_en = 0. It holds at 0xFFFF.
- squash_cnt increments on a case C cycle with branch_taken_ex. It holds at 0xFFFF.

## Timing
- All control outputs are combinational from the current state and inputs, and are valid in the same cycle.
- State and counter updates occur at the rising edge.
- While RST = 1:
  - all en = 0, all flush = 0, pc_en = 0, halt = 0, dwait = 0.
  - At the edge: state becomes RUN and both counters become 0.
- RST in DWAIT or HALT returns the block to RUN on the next edge. There is no residual stall.
- A load-use stall lasts exactly one cycle: the bubble clears idex_memread on the next cycle.
- dhit with ihit in the same cycle follows case C, so the whole pipe advances and exmem_flush = 0.
- Multiple stalls:
  - A data miss freezes the pipe for one cycle per mem_busy cycle.
  - One more stall cycle occurs if ihit is low when dhit arrives.

## Test plan
- Reset, then ihit=1 with no hazards -> all en=1, flushes=0, pc_en=1. stall_cnt stays 0 across 10 cycles.
- Load-use: ihit=1, idex_memread=1, idex_rd=8, ifid_rs=8 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. stall_cnt 0->1. Repeat with idex_rd=0 -> no stall.
- dREN_mem=1, dhit=0 for 3 cycles, then dhit=1 with ihit=0:
  - 3 frozen cycles with dwait=1 after the first edge.
  - Then memwb_en=1, exmem_flush=1, state RUN.
  - stall_cnt = 4.
- branch_taken_ex=1 with load_use=1 and ihit=1 -> ifid_flush=idex_flush=1, pc_en=1. squash_cnt +1, stall_cnt unchanged.
- halt_mem=1 with ihit=1 -> memwb_en=1 that cycle; halt=1 from the next cycle, all en=0. Toggling ihit/dhit for 5 cycles changes nothing. RST -> RUN, halt=0.
- Preload stall_cnt to 0xFFFF via a long DWAIT (65535 cycles) -> it stays at 0xFFFF on further stalls. RST asserted in DWAIT -> RUN and counters 0 after one edge.
